registro_prog: RTL
==================

REGISTRO_PROG -- requirements
Module: registro_prog

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits, minimum 2.
REQ-002 Parameter CNTW, default 4: width of the step-count input AMT.
REQ-003 Parameter TOGW, default 16: width of the toggle counter TOGGLES.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 ENB  input  1  enable; when low, all state holds, including RUN progress.
REQ-007 MODO  input  2  operation: 00 HOLD, 01 PUSH, 10 CYCLE, 11 LOAD.
REQ-008 DIR  input  1  shift direction: 0 toward MSB (left), 1 toward LSB (right).
REQ-009 S_IN  input  1  serial input bit for PUSH.
REQ-010 D  input  WIDTH  parallel load data.
REQ-011 AMT  input  CNTW  number of steps for a multi-step operation.
REQ-012 START  input  1  request for a multi-step PUSH/CYCLE of AMT steps.
REQ-013 Q  output  WIDTH  register contents.
REQ-014 S_OUT  output  1  bit shifted out by the last PUSH step.
REQ-015 BUSY  output  1  high while in RUN.
REQ-016 DONE  output  1  one-cycle pulse marking completion of a multi-step operation.
REQ-017 TOGGLES  output  TOGW  saturating count of Q bit toggles.

Function
REQ-018 The block SHALL have a two-state FSM, IDLE and RUN, with Q, S_OUT, BUSY, DONE and TOGGLES all registered.
REQ-019 Single step: PUSH left gives Q<={Q[W-2:0],S_IN}, S_OUT<=Q[W-1]; PUSH right gives Q<={S_IN,Q[W-1:1]}, S_OUT<=Q[0]; CYCLE rotates one position per DIR with S_OUT<=0; LOAD gives Q<=D with S_OUT<=0; HOLD keeps Q with S_OUT<=0.
REQ-020 In IDLE with ENB=1 and START=0, the block SHALL perform one single step of MODO per edge.
REQ-021 In IDLE with ENB=1, START=1, MODO in {PUSH,CYCLE} and AMT!=0, the block SHALL latch MODO, DIR and AMT on that edge, leave Q unchanged, and enter RUN with BUSY=1.
REQ-022 In RUN, each edge with ENB=1 SHALL perform one step of the latched op/dir and decrement the remaining count; the edge performing the last step SHALL return to IDLE with BUSY<=0 and DONE<=1.
REQ-023 Latency: a START with AMT=N SHALL complete after N enabled RUN edges; DONE is high for exactly the cycle following the last step.
REQ-024 In RUN, the block SHALL ignore MODO, DIR, D, AMT and START, and SHALL sample S_IN on each step.
REQ-025 With START=1 and AMT=0 (PUSH/CYCLE) in IDLE, the block SHALL keep Q, leave BUSY at 0, and assert DONE for one cycle.
REQ-026 With START=1 and MODO HOLD/LOAD, the block SHALL execute an ordinary single step and neither enter RUN nor assert DONE.
REQ-027 With ENB=0, Q, S_OUT, state and count SHALL hold, and DONE SHALL drop to 0.

Reset
REQ-028 RST=1 at an edge SHALL force Q=0, S_OUT=0, BUSY=0, DONE=0, TOGGLES=0 and state IDLE, taking priority over ENB and aborting any RUN in progress.

Configuration
REQ-029 Macro PWR_CNT_EN, when defined: each non-reset edge SHALL add popcount(Q_next XOR Q) to TOGGLES, saturating at all-ones.
REQ-030 Macro PWR_CNT_EN, when undefined: TOGGLES SHALL be constant 0 and no counter logic is built.

Verification (WIDTH=8, CNTW=4)
REQ-031 RST, then LOAD D=0xA5 -> Q=0xA5, S_OUT=0, BUSY=0; TOGGLES=4 if PWR_CNT_EN is defined.
REQ-032 Q=0x81, PUSH DIR=0 S_IN=1 for one edge -> Q=0x03, S_OUT=1.
REQ-033 Q=0x96, START CYCLE DIR=1 AMT=3 -> BUSY high for 3 edges, Q steps 0x4B, 0xA5, 0xD2, then DONE pulses once.
REQ-034 Q=0x00, START PUSH DIR=0 S_IN=1 AMT=4 with ENB low for 2 cycles mid-run -> Q holds while ENB is low, final Q=0x0F, DONE arrives 2 cycles later than without the stall.
REQ-035 RST asserted during RUN -> at the next edge Q=0, BUSY=0, DONE=0, with no DONE pulse afterwards.
REQ-036 START CYCLE AMT=0 with Q=0x3C -> BUSY stays 0, DONE pulses once, Q=0x3C.

Source files
------------

// File: rtl/registro_prog.sv
// registro_prog: programmable shift/rotate/load register with a
// multi-step RUN mode (START + AMT) and an optional toggle counter.
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   ENB           enable; low freezes all state and clears DONE
//   MODO[1:0]     00 HOLD, 01 PUSH, 10 CYCLE, 11 LOAD
//   DIR           0 = toward MSB (left), 1 = toward LSB (right)
//   S_IN          serial input for PUSH
//   D[WIDTH-1:0]  parallel load data
//   AMT[CNTW-1:0] step count for START
//   START         request multi-step PUSH/CYCLE
//   Q, S_OUT      register contents, last bit pushed out
//   BUSY, DONE    RUN indicator, one-cycle completion pulse
//   TOGGLES       saturating count of Q bit toggles
//
// Build option: define PWR_CNT_EN to build the toggle counter;
// otherwise TOGGLES is tied to zero.
module registro_prog #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4,
    parameter int TOGW  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENB,
    input  logic [1:0]       MODO,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [WIDTH-1:0] D,
    input  logic [CNTW-1:0]  AMT,
    input  logic             START,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [TOGW-1:0]  TOGGLES
);

    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_PUSH  = 2'b01;
    localparam logic [1:0] M_CYCLE = 2'b10;
    localparam logic [1:0] M_LOAD  = 2'b11;

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  cnt_next;
    logic [1:0]       op_r;
    logic [1:0]       op_next;
    logic             dir_r;
    logic             dir_next;
    logic [WIDTH-1:0] q_next;
    logic             s_out_next;
    logic             done_next;

    // Operation actually executed this edge: the latched one in RUN.
    logic [1:0]       step_op;
    logic             step_dir;
    logic [WIDTH-1:0] step_q;
    logic             step_s;

    assign step_op  = (state == RUN) ? op_r  : MODO;
    assign step_dir = (state == RUN) ? dir_r : DIR;

    always_comb begin
        step_q = Q;
        step_s = 1'b0;
        unique case (step_op)
            M_HOLD: begin
                step_q = Q;
            end
            M_PUSH: begin
                if (step_dir) begin
                    step_q = {S_IN, Q[WIDTH-1:1]};
                    step_s = Q[0];
                end else begin
                    step_q = {Q[WIDTH-2:0], S_IN};
                    step_s = Q[WIDTH-1];
                end
            end
            M_CYCLE: begin
                if (step_dir) begin
                    step_q = {Q[0], Q[WIDTH-1:1]};
                end else begin
                    step_q = {Q[WIDTH-2:0], Q[WIDTH-1]};
                end
            end
            M_LOAD: begin
                step_q = D;
            end
            default: begin
                step_q = Q;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        op_next    = op_r;
        dir_next   = dir_r;
        q_next     = Q;
        s_out_next = S_OUT;
        done_next  = 1'b0;
        if (ENB) begin
            unique case (state)
                IDLE: begin
                    if (START && (MODO == M_PUSH || MODO == M_CYCLE)) begin
                        // Q is left untouched on the request edge.
                        s_out_next = 1'b0;
                        if (AMT != '0) begin
                            state_next = RUN;
                            cnt_next   = AMT;
                            op_next    = MODO;
                            dir_next   = DIR;
                        end else begin
                            done_next = 1'b1;
                        end
                    end else begin
                        q_next     = step_q;
                        s_out_next = step_s;
                    end
                end
                RUN: begin
                    q_next     = step_q;
                    s_out_next = step_s;
                    cnt_next   = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            op_r  <= M_HOLD;
            dir_r <= 1'b0;
            Q     <= '0;
            S_OUT <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            op_r  <= op_next;
            dir_r <= dir_next;
            Q     <= q_next;
            S_OUT <= s_out_next;
            BUSY  <= (state_next == RUN);
            DONE  <= done_next;
        end
    end

`ifdef PWR_CNT_EN
    logic [WIDTH-1:0] diff;
    logic [TOGW:0]    pop;
    logic [TOGW:0]    tog_sum;

    assign diff = q_next ^ Q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + {{TOGW{1'b0}}, diff[i]};
        end
    end

    // One extra bit catches the carry so the count can saturate.
    assign tog_sum = {1'b0, TOGGLES} + pop;

    always_ff @(posedge CLK) begin
        if (RST) begin
            TOGGLES <= '0;
        end else if (tog_sum[TOGW]) begin
            TOGGLES <= '1;
        end else begin
            TOGGLES <= tog_sum[TOGW-1:0];
        end
    end
`else
    assign TOGGLES = '0;
`endif

endmodule
